prng_multilane_fifo: RTL and testbench

//  Parametrised successor of the 64-bit single-stream RNG: LANES independent xorshift128+

---
 rtl/prng_multilane_fifo.sv | 187 ++++++++++++++++++
 tb/tb_prng_multilane_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/prng_multilane_fifo.sv
// Multi-lane xorshift128+ generator with warm-up discard and output FIFO.
// Optional per-lane repetition check: define PRNG_HEALTH_EN.
`timescale 1ns/1ps
module prng_multilane_fifo #(
    parameter int W      = 64,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4,
    parameter int WARMUP = 8,
    parameter int SH_A   = 23,
    parameter int SH_B   = 17,
    parameter int SH_C   = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               seed_valid,
    input  logic [2*W-1:0]     seed,
    input  logic               rnd_ready,
    output logic               rnd_valid,
    output logic [LANES*W-1:0] rnd_data,
    output logic               seeded,
    output logic [LANES-1:0]   health_err
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int CTW = (WARMUP < 2) ? 1 : $clog2(WARMUP);
    localparam int WL  = (WARMUP == 0) ? 0 : WARMUP - 1;
    localparam logic [CTW-1:0] WLAST = CTW'(WL);
    localparam logic [CW-1:0]  FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_RUN
    } state_e;

    state_e state_q, state_d;
    logic [CTW-1:0] cnt_q, cnt_d;
    logic [LANES-1:0][W-1:0] s0_q, s0_d;
    logic [LANES-1:0][W-1:0] s1_q, s1_d;
    logic [LANES-1:0][W-1:0] nxt1;
    logic [LANES-1:0][W-1:0] word;
    logic [LANES*W-1:0] mem_q [DEPTH];
    logic [LANES*W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          push, step, pop_en;

    // Lane output is taken from the state before it advances.
    always_comb begin
        word = '0;
        nxt1 = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [W-1:0] t;
            word[i] = s0_q[i] + s1_q[i];
            t = s0_q[i];
            t = t ^ (t << SH_A);
            t = t ^ (t >> SH_B);
            t = t ^ s1_q[i] ^ (s1_q[i] >> SH_C);
            nxt1[i] = t;
        end
    end

`ifdef PRNG_HEALTH_EN
    logic [LANES-1:0][W-1:0] last_q, last_d;
    logic                    have_q, have_d;
    logic [LANES-1:0]        herr_q, herr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        push    = 1'b0;
        step    = 1'b0;
        pop_en  = valid_q & rnd_ready & ~seed_valid;
`ifdef PRNG_HEALTH_EN
        last_d  = last_q;
        have_d  = have_q;
        herr_d  = herr_q;
`endif
        if (!seed_valid) begin
            unique case (state_q)
                ST_WARM: begin
                    step = 1'b1;
                    if (cnt_q == WLAST) state_d = ST_RUN;
                    else cnt_d = cnt_q + 1'b1;
                end
                ST_RUN: begin
                    // Full FIFO freezes the generator so nothing is skipped.
                    push = (count_q != FULL) | pop_en;
                    step = push;
                end
                default: ;
            endcase
        end

        if (step) begin
            s0_d = s1_q;
            s1_d = nxt1;
        end
        if (push) begin
            mem_d[wr_q] = word;
            wr_d = wr_q + 1'b1;
`ifdef PRNG_HEALTH_EN
            for (int i = 0; i < LANES; i++)
                if (have_q && word[i] == last_q[i]) herr_d[i] = 1'b1;
            last_d = word;
            have_d = 1'b1;
`endif
        end
        if (pop_en) rd_d = rd_q + 1'b1;
        if (push && !pop_en) count_d = count_q + 1'b1;
        else if (!push && pop_en) count_d = count_q - 1'b1;

        if (seed_valid) begin
            for (int i = 0; i < LANES; i++) begin
                s0_d[i] = seed[2*W-1:W] + W'(i);
                s1_d[i] = seed[W-1:0] ^ (W'(i) << 1);
                if (s0_d[i] == '0 && s1_d[i] == '0) s1_d[i] = W'(1);
            end
            state_d = (WARMUP == 0) ? ST_RUN : ST_WARM;
            cnt_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
`ifdef PRNG_HEALTH_EN
            have_d  = 1'b0;
            herr_d  = '0;
`endif
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s0_q    <= '0;
            s1_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            for (int j = 0; j < DEPTH; j++) mem_q[j] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            valid_q <= valid_d;
            for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
        end
    end

`ifdef PRNG_HEALTH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            have_q <= 1'b0;
            herr_q <= '0;
        end else begin
            last_q <= last_d;
            have_q <= have_d;
            herr_q <= herr_d;
        end
    end
    assign health_err = herr_q;
`else
    assign health_err = '0;
`endif

    assign rnd_valid = valid_q;
    assign rnd_data  = valid_q ? mem_q[rd_q] : '0;
    assign seeded    = (state_q == ST_RUN);

endmodule

// File: tb/tb_prng_multilane_fifo.sv
// Directed checks for prng_multilane_fifo (WARMUP=0 and WARMUP=8 instances).
`timescale 1ns/1ps
module tb_prng_multilane_fifo;

    logic         clk;
    logic         rst_n;
    logic         seed_valid;
    logic [127:0] seed;
    logic         rnd_ready;
    logic         rnd_valid;
    logic [255:0] rnd_data;
    logic         seeded;
    logic [3:0]   health_err;

    logic         seed8_valid;
    logic [127:0] seed8;
    logic         ready8;
    logic         valid8;
    logic [255:0] data8;
    logic         seeded8;
    logic [3:0]   herr8;

    int errs;
    int checks;

    logic [63:0] ms0 [4];
    logic [63:0] ms1 [4];
    logic [255:0] hold;

    prng_multilane_fifo #(.WARMUP(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(seed_valid), .seed(seed),
        .rnd_ready(rnd_ready), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .seeded(seeded),
        .health_err(health_err)
    );

    prng_multilane_fifo #(.WARMUP(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .seed_valid(seed8_valid), .seed(seed8),
        .rnd_ready(ready8), .rnd_valid(valid8),
        .rnd_data(data8), .seeded(seeded8),
        .health_err(herr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_seed(input logic [127:0] s);
        seed = s;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic m_seed(input logic [127:0] s);
        for (int i = 0; i < 4; i++) begin
            ms0[i] = s[127:64] + 64'(i);
            ms1[i] = s[63:0] ^ (64'(i) << 1);
            if (ms0[i] == 0 && ms1[i] == 0) ms1[i] = 64'd1;
        end
    endtask

    task automatic m_step();
        logic [63:0] t;
        for (int i = 0; i < 4; i++) begin
            t = ms0[i];
            t = t ^ (t << 23);
            t = t ^ (t >> 17);
            t = t ^ ms1[i] ^ (ms1[i] >> 26);
            ms0[i] = ms1[i];
            ms1[i] = t;
        end
    endtask

    function automatic logic [255:0] m_beat();
        logic [255:0] b;
        for (int i = 0; i < 4; i++) b[i*64 +: 64] = ms0[i] + ms1[i];
        return b;
    endfunction

    localparam logic [127:0] S1 = {64'h0123456789abcdef,
                                   64'hfedcba9876543210};

    initial begin
        errs = 0;
        checks = 0;
        rst_n = 1'b0;
        seed_valid = 1'b0;
        seed = '0;
        rnd_ready = 1'b0;
        seed8_valid = 1'b0;
        seed8 = '0;
        ready8 = 1'b1;
        tick();
        chk("rst_valid", 256'(rnd_valid), 256'd0);
        chk("rst_seeded", 256'(seeded), 256'd0);
        chk("rst_data", rnd_data, 256'd0);
        chk("rst_herr", 256'(health_err), 256'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_valid", 256'(rnd_valid), 256'd0);

        // Basic sequence from seed {0,1}
        rnd_ready = 1'b1;
        do_seed({64'h0, 64'h1});
        chk("a_seeded", 256'(seeded), 256'd1);
        chk("a_valid_e0", 256'(rnd_valid), 256'd0);
        tick();
        chk("a_valid_e1", 256'(rnd_valid), 256'd1);
        chk("a_beat0", rnd_data,
            {64'd10, 64'd7, 64'd4, 64'd1});
        tick();
        chk("a_l0_w2", 256'(rnd_data[63:0]), 256'd2);
        tick();
        chk("a_l0_w3", 256'(rnd_data[63:0]), 256'h800041);

        // Stall: fill, hold 100 cycles, then drain
        rnd_ready = 1'b0;
        do_seed(S1);
        m_seed(S1);
        repeat (4) tick();
        hold = rnd_data;
        chk("st_head", hold, m_beat());
        repeat (100) tick();
        chk("st_valid", 256'(rnd_valid), 256'd1);
        chk("st_stable", rnd_data, hold);
        rnd_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("st_beat%0d", k), rnd_data, m_beat());
            m_step();
            tick();
        end

        // Reseed with 3 queued entries
        rnd_ready = 1'b0;
        do_seed(S1);
        repeat (3) tick();
        chk("rs_valid_q3", 256'(rnd_valid), 256'd1);
        do_seed(S1);
        chk("rs_flushed", 256'(rnd_valid), 256'd0);
        m_seed(S1);
        rnd_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rs_beat%0d", k), rnd_data, m_beat());
            m_step();
            tick();
        end

        // All-zero seed
        do_seed(128'h0);
        tick();
        chk("z_l0_w1", 256'(rnd_data[63:0]), 256'd1);
        chk("z_l1_w1", 256'(rnd_data[127:64]), 256'd3);
        tick();
        chk("z_l0_w2", 256'(rnd_data[63:0]), 256'd2);
        repeat (5) tick();
        chk("z_nonzero", 256'(rnd_data[63:0] != 0), 256'd1);
`ifndef PRNG_HEALTH_EN
        chk("herr_off", 256'(health_err), 256'd0);
`endif

        // Warm-up latency on the WARMUP=8 instance
        seed8 = S1;
        seed8_valid = 1'b1;
        tick();
        seed8_valid = 1'b0;
        m_seed(S1);
        repeat (8) m_step();
        repeat (7) tick();
        chk("w_seeded_e7", 256'(seeded8), 256'd0);
        chk("w_valid_e7", 256'(valid8), 256'd0);
        tick();
        chk("w_seeded_e8", 256'(seeded8), 256'd1);
        chk("w_valid_e8", 256'(valid8), 256'd0);
        tick();
        chk("w_valid_e9", 256'(valid8), 256'd1);
        chk("w_beat0", data8, m_beat());

        // Async reset while running
        chk("r_pre_valid", 256'(rnd_valid), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_valid", 256'(rnd_valid), 256'd0);
        chk("r_seeded", 256'(seeded), 256'd0);
        chk("r_data", rnd_data, 256'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("r_noseed_valid", 256'(rnd_valid), 256'd0);
        chk("r_noseed_seeded", 256'(seeded), 256'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
